// File: rtl/wb_stage_if.sv
// Handshake/data bundle between MEM2, the write-back stage and its consumers.
// The slave modport is the write-back stage; the master modport is the environment around it.
interface wb_stage_if;
  logic        WB_Flush;
  logic        WB_Wr;
  logic        MEM2_Valid;
  logic [31:0] MEM2_ALUOut;
  logic [31:0] MEM2_PC;
  logic [31:0] MEM2_Instr;
  logic [1:0]  MEM2_WbSel;
  logic [4:0]  MEM2_Dst;
  logic [2:0]  MEM2_LoadType;
  logic [31:0] MEM2_OutB;
  logic [2:0]  MEM2_RegsWrType;
  logic [31:0] MEM_DMOut;
  logic [31:0] WB_Result;
  logic [4:0]  WB_Dst;
  logic [2:0]  WB_RegsWrType;
  logic [31:0] WB_PC;
  logic        WB_Valid;
  logic        RF_We;
  logic [4:0]  RF_Waddr;
  logic [31:0] RF_Wdata;
  logic [31:0] WB_RetireCnt;

  modport slave (
    input  WB_Flush, WB_Wr, MEM2_Valid, MEM2_ALUOut, MEM2_PC, MEM2_Instr, MEM2_WbSel,
           MEM2_Dst, MEM2_LoadType, MEM2_OutB, MEM2_RegsWrType, MEM_DMOut,
    output WB_Result, WB_Dst, WB_RegsWrType, WB_PC, WB_Valid, RF_We, RF_Waddr,
           RF_Wdata, WB_RetireCnt
  );

  modport master (
    output WB_Flush, WB_Wr, MEM2_Valid, MEM2_ALUOut, MEM2_PC, MEM2_Instr, MEM2_WbSel,
           MEM2_Dst, MEM2_LoadType, MEM2_OutB, MEM2_RegsWrType, MEM_DMOut,
    input  WB_Result, WB_Dst, WB_RegsWrType, WB_PC, WB_Valid, RF_We, RF_Waddr,
           RF_Wdata, WB_RetireCnt
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: registers MEM2 plus the dbus read word, extracts/merges load data,
// selects the write-back value, drives the regfile port and counts retired instructions.
module wb_stage (
  input  logic       clk,
  input  logic       rst,
  wb_stage_if.slave  bus
);

  logic        valid_q;
  logic [31:0] alu_q;
  logic [31:0] pc_q;
  logic [31:0] outb_q;
  logic [31:0] dm_q;
  logic [1:0]  sel_q;
  logic [4:0]  dst_q;
  logic [2:0]  lt_q;
  logic [2:0]  rwt_q;
  logic [31:0] retire_cnt;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] result;

  // The read word is captured here so a stall never needs the cache to re-read.
  // The instruction word has no consumer past MEM2 decode, so it is not stored.
  always_ff @(posedge clk) begin
    if (rst || bus.WB_Flush) begin
      valid_q <= 1'b0;
      alu_q   <= 32'd0;
      pc_q    <= 32'd0;
      outb_q  <= 32'd0;
      dm_q    <= 32'd0;
      sel_q   <= 2'd0;
      dst_q   <= 5'd0;
      lt_q    <= 3'd0;
      rwt_q   <= 3'd0;
    end else if (bus.WB_Wr) begin
      valid_q <= bus.MEM2_Valid;
      alu_q   <= bus.MEM2_ALUOut;
      pc_q    <= bus.MEM2_PC;
      outb_q  <= bus.MEM2_OutB;
      dm_q    <= bus.MEM_DMOut;
      sel_q   <= bus.MEM2_WbSel;
      dst_q   <= bus.MEM2_Dst;
      lt_q    <= bus.MEM2_LoadType;
      rwt_q   <= bus.MEM2_RegsWrType;
    end
  end

  // Counted as the instruction leaves WB; a flushed instruction is discarded uncounted.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= 32'd0;
    end else if (valid_q && bus.WB_Wr && !bus.WB_Flush) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

  always_comb begin
    byte_sel = dm_q[7:0];
    case (alu_q[1:0])
      2'd1:    byte_sel = dm_q[15:8];
      2'd2:    byte_sel = dm_q[23:16];
      2'd3:    byte_sel = dm_q[31:24];
      default: byte_sel = dm_q[7:0];
    endcase
    half_sel = alu_q[1] ? dm_q[31:16] : dm_q[15:0];
  end

  always_comb begin
    load_data = dm_q;
    case (lt_q)
      3'd1: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'd2: load_data = {24'd0, byte_sel};
      3'd3: load_data = {{16{half_sel[15]}}, half_sel};
      3'd4: load_data = {16'd0, half_sel};
      3'd5: begin
        case (alu_q[1:0])
          2'd0:    load_data = {dm_q[7:0],  outb_q[23:0]};
          2'd1:    load_data = {dm_q[15:0], outb_q[15:0]};
          2'd2:    load_data = {dm_q[23:0], outb_q[7:0]};
          default: load_data = dm_q;
        endcase
      end
      3'd6: begin
        case (alu_q[1:0])
          2'd1:    load_data = {outb_q[31:24], dm_q[31:8]};
          2'd2:    load_data = {outb_q[31:16], dm_q[31:16]};
          2'd3:    load_data = {outb_q[31:8],  dm_q[31:24]};
          default: load_data = dm_q;
        endcase
      end
      default: load_data = dm_q;
    endcase
  end

  always_comb begin
    result = pc_q + 32'd8;
    case (sel_q)
      2'd1:    result = alu_q;
      2'd2:    result = outb_q;
      2'd3:    result = load_data;
      default: result = pc_q + 32'd8;
    endcase
  end

  // While stalled the same write repeats each cycle, which is harmless.
  assign bus.WB_Result     = result;
  assign bus.WB_Dst        = dst_q;
  assign bus.WB_RegsWrType = valid_q ? rwt_q : 3'd0;
  assign bus.WB_PC         = pc_q;
  assign bus.WB_Valid      = valid_q;
  assign bus.RF_We         = valid_q & rwt_q[2] & (dst_q != 5'd0);
  assign bus.RF_Waddr      = dst_q;
  assign bus.RF_Wdata      = result;
  assign bus.WB_RetireCnt  = retire_cnt;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the write-back register and retire counter.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_stage_if bus();

  wb_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of what WB currently holds
  logic        m_valid;
  logic [31:0] m_alu, m_pc, m_outb, m_dm, m_cnt;
  logic [1:0]  m_sel;
  logic [4:0]  m_dst;
  logic [2:0]  m_lt, m_rwt;

  function automatic logic [31:0] ref_load();
    int o;
    int sh;
    logic [7:0]  b;
    logic [15:0] h;
    o = int'(m_alu[1:0]);
    b = 8'(m_dm >> (8 * o));
    h = 16'(m_dm >> (16 * (o / 2)));
    case (m_lt)
      3'd1: return {{24{b[7]}}, b};
      3'd2: return {24'd0, b};
      3'd3: return {{16{h[15]}}, h};
      3'd4: return {16'd0, h};
      3'd5: begin
        sh = 8 * (3 - o);
        return (m_dm << sh) | (m_outb & ((32'd1 << sh) - 32'd1));
      end
      3'd6: begin
        sh = 8 * o;
        return (m_dm >> sh) | (m_outb & ~(32'hFFFF_FFFF >> sh));
      end
      default: return m_dm;
    endcase
  endfunction

  function automatic logic [31:0] ref_result();
    case (m_sel)
      2'd0:    return m_pc + 32'd8;
      2'd1:    return m_alu;
      2'd2:    return m_outb;
      default: return ref_load();
    endcase
  endfunction

  function automatic logic ref_we();
    return m_valid && m_rwt[2] && (m_dst != 5'd0);
  endfunction

  task automatic set_in(input logic v, input logic [31:0] alu, input logic [31:0] pc,
                        input logic [1:0] sel, input logic [4:0] dst, input logic [2:0] lt,
                        input logic [31:0] outb, input logic [2:0] rwt, input logic [31:0] dm);
    bus.MEM2_Valid      = v;
    bus.MEM2_ALUOut     = alu;
    bus.MEM2_PC         = pc;
    bus.MEM2_Instr      = $urandom;
    bus.MEM2_WbSel      = sel;
    bus.MEM2_Dst        = dst;
    bus.MEM2_LoadType   = lt;
    bus.MEM2_OutB       = outb;
    bus.MEM2_RegsWrType = rwt;
    bus.MEM_DMOut       = dm;
  endtask

  // Apply one clock edge with the given controls and advance the model alongside it.
  task automatic clock(input logic r, input logic f, input logic w);
    logic        n_valid;
    logic [31:0] n_alu, n_pc, n_outb, n_dm, n_cnt;
    logic [1:0]  n_sel;
    logic [4:0]  n_dst;
    logic [2:0]  n_lt, n_rwt;
    rst = r;
    bus.WB_Flush = f;
    bus.WB_Wr = w;
    {n_valid, n_alu, n_pc, n_outb, n_dm, n_sel, n_dst, n_lt, n_rwt} =
      {m_valid, m_alu, m_pc, m_outb, m_dm, m_sel, m_dst, m_lt, m_rwt};
    n_cnt = m_cnt;
    if (r || f) begin
      {n_valid, n_alu, n_pc, n_outb, n_dm, n_sel, n_dst, n_lt, n_rwt} = '0;
    end else if (w) begin
      n_valid = bus.MEM2_Valid;      n_alu = bus.MEM2_ALUOut;
      n_pc    = bus.MEM2_PC;         n_outb = bus.MEM2_OutB;
      n_dm    = bus.MEM_DMOut;       n_sel = bus.MEM2_WbSel;
      n_dst   = bus.MEM2_Dst;        n_lt  = bus.MEM2_LoadType;
      n_rwt   = bus.MEM2_RegsWrType;
    end
    if (r) n_cnt = 32'd0;
    else if (m_valid && w && !f) n_cnt = m_cnt + 32'd1;
    @(posedge clk);
    #1;
    {m_valid, m_alu, m_pc, m_outb, m_dm, m_sel, m_dst, m_lt, m_rwt} =
      {n_valid, n_alu, n_pc, n_outb, n_dm, n_sel, n_dst, n_lt, n_rwt};
    m_cnt = n_cnt;
  endtask

  task automatic test_reset();
    set_in(1'b1, $urandom, $urandom, 2'd1, 5'd9, 3'd0, $urandom, 3'b100, $urandom);
    clock(1'b1, 1'b0, 1'b1);
    clock(1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus.WB_Valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", bus.WB_Valid); end
    n_cmp++; if (bus.RF_We !== 1'b0) begin n_err++; $display("FAIL reset_we got %0b want 0", bus.RF_We); end
    n_cmp++; if (bus.WB_Result !== 32'd8) begin n_err++; $display("FAIL reset_result got %h want 00000008", bus.WB_Result); end
    n_cmp++; if (bus.WB_RetireCnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %h want 0", bus.WB_RetireCnt); end
    n_cmp++; if ({bus.WB_Dst, bus.WB_RegsWrType, bus.WB_PC} !== 40'd0) begin
      n_err++; $display("FAIL reset_fields got dst=%0d rwt=%0d pc=%h want 0", bus.WB_Dst, bus.WB_RegsWrType, bus.WB_PC);
    end
  endtask

  task automatic test_byte_load();
    set_in(1'b1, 32'h1000_0003, 32'h400, 2'd3, 5'd5, 3'd1, 32'h0, 3'b100, 32'h80FF_1234);
    clock(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.RF_We !== 1'b1 || bus.RF_Waddr !== 5'd5) begin
      n_err++; $display("FAIL lb_port got we=%0b waddr=%0d want we=1 waddr=5", bus.RF_We, bus.RF_Waddr);
    end
    n_cmp++; if (bus.RF_Wdata !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_data got %h want ffffff80", bus.RF_Wdata); end
    set_in(1'b1, 32'h1000_0003, 32'h404, 2'd3, 5'd5, 3'd2, 32'h0, 3'b100, 32'h80FF_1234);
    clock(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.RF_Wdata !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_data got %h want 00000080", bus.RF_Wdata); end
  endtask

  task automatic test_merge();
    set_in(1'b1, 32'h2000_0001, 32'h408, 2'd3, 5'd6, 3'd5, 32'h1122_3344, 3'b100, 32'hAABB_CCDD);
    clock(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.WB_Result !== 32'hCCDD_3344) begin n_err++; $display("FAIL lwl_o1 got %h want ccdd3344", bus.WB_Result); end
    set_in(1'b1, 32'h2000_0002, 32'h40C, 2'd3, 5'd6, 3'd6, 32'h1122_3344, 3'b100, 32'hAABB_CCDD);
    clock(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.WB_Result !== 32'h1122_AABB) begin n_err++; $display("FAIL lwr_o2 got %h want 1122aabb", bus.WB_Result); end
  endtask

  task automatic test_stall();
    logic [31:0] c0;
    set_in(1'b1, 32'h3000_0002, 32'h410, 2'd3, 5'd7, 3'd3, 32'h0, 3'b100, 32'h8001_0000);
    clock(1'b0, 1'b0, 1'b1);
    c0 = m_cnt;
    n_cmp++; if (bus.WB_Result !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_o2 got %h want ffff8001", bus.WB_Result); end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, $urandom, $urandom, 2'($urandom), 5'($urandom), 3'($urandom), $urandom, 3'($urandom), ~bus.MEM_DMOut);
      clock(1'b0, 1'b0, 1'b0);
      n_cmp++; if (bus.WB_Result !== 32'hFFFF_8001 || bus.RF_We !== 1'b1) begin
        n_err++; $display("FAIL stall_hold got %h we=%0b want ffff8001 we=1", bus.WB_Result, bus.RF_We);
      end
      n_cmp++; if (bus.WB_RetireCnt !== c0) begin n_err++; $display("FAIL stall_cnt got %h want %h", bus.WB_RetireCnt, c0); end
    end
    set_in(1'b0, 32'h0, 32'h0, 2'd1, 5'd0, 3'd0, 32'h0, 3'b000, 32'h0);
    clock(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.WB_RetireCnt !== c0 + 32'd1) begin n_err++; $display("FAIL stall_release_cnt got %h want %h", bus.WB_RetireCnt, c0 + 32'd1); end
    n_cmp++; if (bus.WB_Valid !== 1'b0 || bus.RF_We !== 1'b0) begin
      n_err++; $display("FAIL bubble got valid=%0b we=%0b want 0 0", bus.WB_Valid, bus.RF_We);
    end
  endtask

  task automatic test_flush();
    logic [31:0] c0;
    set_in(1'b1, 32'h55, 32'h500, 2'd1, 5'd3, 3'd0, 32'h0, 3'b100, 32'h0);
    clock(1'b0, 1'b0, 1'b1);
    c0 = m_cnt;
    set_in(1'b1, 32'h66, 32'h504, 2'd1, 5'd4, 3'd0, 32'h0, 3'b100, 32'h0);
    clock(1'b0, 1'b1, 1'b1);
    n_cmp++; if (bus.WB_Valid !== 1'b0 || bus.RF_We !== 1'b0) begin
      n_err++; $display("FAIL flush_clear got valid=%0b we=%0b want 0 0", bus.WB_Valid, bus.RF_We);
    end
    n_cmp++; if (bus.WB_RetireCnt !== c0) begin n_err++; $display("FAIL flush_cnt got %h want %h", bus.WB_RetireCnt, c0); end
  endtask

  task automatic test_pc8();
    set_in(1'b1, $urandom, 32'hBFC0_0010, 2'd0, 5'd31, 3'd0, $urandom, 3'b100, $urandom);
    clock(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.RF_Wdata !== 32'hBFC0_0018 || bus.RF_We !== 1'b1) begin
      n_err++; $display("FAIL jal_r31 got %h we=%0b want bfc00018 we=1", bus.RF_Wdata, bus.RF_We);
    end
    set_in(1'b1, $urandom, 32'hBFC0_0010, 2'd0, 5'd0, 3'd0, $urandom, 3'b100, $urandom);
    clock(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.RF_We !== 1'b0) begin n_err++; $display("FAIL jal_r0 got we=%0b want 0", bus.RF_We); end
    set_in(1'b1, $urandom, 32'hFFFF_FFFC, 2'd0, 5'd2, 3'd0, $urandom, 3'b100, $urandom);
    clock(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.WB_Result !== 32'h0000_0004) begin n_err++; $display("FAIL pc8_wrap got %h want 00000004", bus.WB_Result); end
  endtask

  task automatic test_random();
    logic r, f, w;
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom), $urandom, $urandom, 2'($urandom), 5'($urandom % 8), 3'($urandom),
             $urandom, 3'($urandom), $urandom);
      r = ($urandom % 64) == 0;
      f = ($urandom % 8) == 0;
      w = ($urandom % 4) != 0;
      clock(r, f, w);
      n_cmp++; if (bus.WB_Result !== ref_result()) begin n_err++; $display("FAIL rnd_result[%0d] got %h want %h", i, bus.WB_Result, ref_result()); end
      n_cmp++; if (bus.RF_We !== ref_we() || bus.RF_Waddr !== m_dst) begin
        n_err++; $display("FAIL rnd_rf[%0d] got we=%0b a=%0d want we=%0b a=%0d", i, bus.RF_We, bus.RF_Waddr, ref_we(), m_dst);
      end
      n_cmp++; if (bus.WB_Valid !== m_valid || bus.WB_PC !== m_pc || bus.WB_Dst !== m_dst) begin
        n_err++; $display("FAIL rnd_fields[%0d] got v=%0b pc=%h d=%0d want v=%0b pc=%h d=%0d", i,
                          bus.WB_Valid, bus.WB_PC, bus.WB_Dst, m_valid, m_pc, m_dst);
      end
      n_cmp++; if (bus.WB_RegsWrType !== (m_valid ? m_rwt : 3'd0)) begin
        n_err++; $display("FAIL rnd_rwt[%0d] got %0d want %0d", i, bus.WB_RegsWrType, m_valid ? m_rwt : 3'd0);
      end
      n_cmp++; if (bus.WB_RetireCnt !== m_cnt || bus.RF_Wdata !== ref_result()) begin
        n_err++; $display("FAIL rnd_cnt[%0d] got %h wdata=%h want %h wdata=%h", i, bus.WB_RetireCnt, bus.RF_Wdata, m_cnt, ref_result());
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    set_in(1'b0, 32'h0, 32'h0, 2'd0, 5'd0, 3'd0, 32'h0, 3'b000, 32'h0);
    clock(1'b0, 1'b0, 1'b1);
    dut.retire_cnt = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    set_in(1'b1, 32'h77, 32'h600, 2'd1, 5'd8, 3'd0, 32'h0, 3'b100, 32'h0);
    clock(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.WB_RetireCnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_pre got %h want ffffffff", bus.WB_RetireCnt); end
    set_in(1'b1, 32'h88, 32'h604, 2'd1, 5'd9, 3'd0, 32'h0, 3'b100, 32'h0);
    clock(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.WB_RetireCnt !== 32'd0) begin n_err++; $display("FAIL wrap_zero got %h want 0", bus.WB_RetireCnt); end
    clock(1'b0, 1'b0, 1'b0);
    clock(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.WB_Valid !== 1'b0 || bus.RF_We !== 1'b0 || bus.WB_Result !== 32'd8) begin
      n_err++; $display("FAIL rst_stall got v=%0b we=%0b res=%h want 0 0 00000008", bus.WB_Valid, bus.RF_We, bus.WB_Result);
    end
    n_cmp++; if (bus.WB_RetireCnt !== 32'd0 || bus.WB_PC !== 32'd0 || bus.WB_Dst !== 5'd0 || bus.WB_RegsWrType !== 3'd0) begin
      n_err++; $display("FAIL rst_stall_fields got cnt=%h pc=%h dst=%0d rwt=%0d want 0", bus.WB_RetireCnt, bus.WB_PC, bus.WB_Dst, bus.WB_RegsWrType);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.WB_Flush = 1'b0;
    bus.WB_Wr = 1'b0;
    {m_valid, m_alu, m_pc, m_outb, m_dm, m_sel, m_dst, m_lt, m_rwt} = '0;
    m_cnt = 32'd0;
    test_reset();
    test_byte_load();
    test_merge();
    test_stall();
    test_flush();
    test_pc8();
    test_random();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
